// File: rtl/screen_sequencer_if.sv
// ----------------------------------------------------------------------------
// vga_pkg / screen_sequencer_if
//
// vga_pkg carries the screen selection type shared by the sequencer and the
// screen selector.
//
// screen_sequencer_if groups the game-flow signals of the screen sequencer.
//   vblnk      vertical blank from the VGA timing chain (rising edge = frame)
//   btn_start  start button level, already synchronised to the pixel clock
//   p1_won     player-1 win event (pulse or level)
//   p2_won     player-2 win event (pulse or level)
//   screen     current screen selection
//   game_rst   one-cycle reset pulse to the game logic on each new game
//   frame_cnt  frames elapsed on the current win screen
//
// Modports:
//   master  the sequencer: consumes the events, drives screen/game_rst/frame_cnt
//   slave   the surrounding system: drives the events, consumes the outputs
//
// WIN_FRAMES must match the WIN_FRAMES of the attached sequencer so that the
// frame_cnt widths agree.
// ----------------------------------------------------------------------------
package vga_pkg;
    typedef enum logic [1:0] {
        START    = 2'd0,
        GAME     = 2'd1,
        PLAYER_1 = 2'd2,
        PLAYER_2 = 2'd3
    } state;
endpackage

interface screen_sequencer_if #(
    parameter int WIN_FRAMES = 300
);
    localparam int CNT_W = $clog2(WIN_FRAMES + 1);

    logic             vblnk;
    logic             btn_start;
    logic             p1_won;
    logic             p2_won;
    vga_pkg::state    screen;
    logic             game_rst;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        input  vblnk,
        input  btn_start,
        input  p1_won,
        input  p2_won,
        output screen,
        output game_rst,
        output frame_cnt
    );

    modport slave (
        output vblnk,
        output btn_start,
        output p1_won,
        output p2_won,
        input  screen,
        input  game_rst,
        input  frame_cnt
    );
endinterface

// File: rtl/screen_sequencer.sv
// ----------------------------------------------------------------------------
// screen_sequencer
//
// Game-flow controller. Chooses which screen is shown (START, GAME, PLAYER_1,
// PLAYER_2) from the start button and the win events of the game logic.
// Screen changes only happen on a frame boundary (rising edge of vblnk) so a
// switch never tears the picture. Requests seen between boundaries are held
// in sticky flags until the next boundary.
//
// Ports:
//   clk   pixel clock
//   rst   synchronous, active-high reset
//   bus   screen_sequencer_if.master: vblnk, btn_start, p1_won, p2_won in;
//         screen, game_rst, frame_cnt out (all outputs registered)
//
// The screen register is the FSM state; it is exposed directly on bus.screen.
// ----------------------------------------------------------------------------
module screen_sequencer #(
    parameter int WIN_FRAMES = 300
) (
    input  logic                       clk,
    input  logic                       rst,
    screen_sequencer_if.master         bus
);
    import vga_pkg::*;

    localparam int               CNT_W    = $clog2(WIN_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_FRAMES - 1);

    state             screen_q,   screen_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             game_rst_q, game_rst_d;
    logic             start_q,    start_d;
    logic             win1_q,     win1_d;
    logic             win2_q,     win2_d;
    logic             vblnk_q;
    logic             btn_q;

    logic             frame_tick;
    logic             start_edge;
    logic             move;

    assign frame_tick = bus.vblnk & ~vblnk_q;
    assign start_edge = bus.btn_start & ~btn_q;

    always_comb begin
        screen_d   = screen_q;
        cnt_d      = cnt_q;
        game_rst_d = 1'b0;
        start_d    = start_q;
        win1_d     = win1_q;
        win2_d     = win2_q;
        move       = 1'b0;

        // Decisions use only flags latched in earlier cycles, so a request
        // arriving together with a tick waits for the following tick.
        case (screen_q)
            START: begin
                if (frame_tick && start_q) begin
                    screen_d   = GAME;
                    game_rst_d = 1'b1;
                    move       = 1'b1;
                end
            end
            GAME: begin
                if (frame_tick && win1_q) begin
                    // Player 1 takes precedence when both wins are pending.
                    screen_d = PLAYER_1;
                    move     = 1'b1;
                end else if (frame_tick && win2_q) begin
                    screen_d = PLAYER_2;
                    move     = 1'b1;
                end
            end
            PLAYER_1, PLAYER_2: begin
                if (frame_tick) begin
                    if (start_q || (cnt_q == CNT_LAST)) begin
                        screen_d = START;
                        move     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // Unknown encoding: recover at once, no frame boundary needed.
                screen_d = START;
                move     = 1'b1;
            end
        endcase

        if (move) begin
            // A transition discards everything pending, including a press or
            // win event arriving in this very cycle.
            cnt_d   = '0;
            start_d = 1'b0;
            win1_d  = 1'b0;
            win2_d  = 1'b0;
        end else begin
            if (start_edge && (screen_q != GAME)) begin
                start_d = 1'b1;
            end
            if (screen_q == GAME) begin
                if (bus.p1_won) win1_d = 1'b1;
                if (bus.p2_won) win2_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            screen_q   <= START;
            cnt_q      <= '0;
            game_rst_q <= 1'b0;
            start_q    <= 1'b0;
            win1_q     <= 1'b0;
            win2_q     <= 1'b0;
            vblnk_q    <= 1'b0;
            btn_q      <= 1'b0;
        end else begin
            screen_q   <= screen_d;
            cnt_q      <= cnt_d;
            game_rst_q <= game_rst_d;
            start_q    <= start_d;
            win1_q     <= win1_d;
            win2_q     <= win2_d;
            vblnk_q    <= bus.vblnk;
            btn_q      <= bus.btn_start;
        end
    end

    assign bus.screen    = screen_q;
    assign bus.game_rst  = game_rst_q;
    assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;
    import vga_pkg::*;

    localparam int WIN = 3;
    localparam int FRAME = 20;

    logic clk;
    logic rst;

    screen_sequencer_if #(.WIN_FRAMES(WIN)) bus ();

    screen_sequencer #(.WIN_FRAMES(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst           = 1'b1;
        bus.vblnk     = 1'b0;
        bus.btn_start = 1'b0;
        bus.p1_won    = 1'b0;
        bus.p2_won    = 1'b0;
    end

    // scoreboard counters
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;          // after a step: index of the cycle now visible
    int grst_cnt = 0;     // observed game_rst pulses
    bit seen_p1 = 0;
    bit seen_p2 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: the game flow described as screens, pending requests
    // and a count of frames spent on a win screen.
    state     m_screen = START;
    int       m_frames = 0;
    bit       m_grst   = 0;
    bit       m_start  = 0;
    bit [1:0] m_won    = 2'b00;   // bit0: player 1 pending, bit1: player 2
    bit       m_vb     = 0;
    bit       m_btn    = 0;

    task automatic model_step(input bit r, input bit vb, input bit b, input bit p1, input bit p2);
        state old;
        bit   tick;
        bit   press;
        bit   moved;
        if (r) begin
            m_screen = START;
            m_frames = 0;
            m_grst   = 0;
            m_start  = 0;
            m_won    = 2'b00;
            m_vb     = 0;
            m_btn    = 0;
            return;
        end
        old    = m_screen;
        tick   = vb && !m_vb;
        press  = b && !m_btn;
        moved  = 0;
        m_grst = 0;
        if (tick) begin
            if (old == START) begin
                if (m_start) begin
                    m_screen = GAME;
                    m_grst   = 1;
                    moved    = 1;
                end
            end else if (old == GAME) begin
                if (m_won != 2'b00) begin
                    m_screen = m_won[0] ? PLAYER_1 : PLAYER_2;
                    moved    = 1;
                end
            end else begin
                // WIN ticks spent on the win screen means time to go home
                if (m_start || (m_frames + 1 == WIN)) begin
                    m_screen = START;
                    moved    = 1;
                end else begin
                    m_frames = m_frames + 1;
                end
            end
        end
        if (moved) begin
            m_start  = 0;
            m_won    = 2'b00;
            m_frames = 0;
        end else begin
            if (press && old != GAME) m_start = 1;
            if (old == GAME) m_won = m_won | {p2, p1};
        end
        m_vb  = vb;
        m_btn = b;
    endtask

    // driver: one clock cycle with the given inputs, then compare to model
    task automatic step(input bit r, input bit b, input bit p1, input bit p2);
        bit vb;
        vb            = ((cyc % FRAME) >= 15);
        rst           = r;
        bus.vblnk     = vb;
        bus.btn_start = b;
        bus.p1_won    = p1;
        bus.p2_won    = p2;
        model_step(r, vb, b, p1, p2);
        @(posedge clk);
        #1;
        cyc++;
        check("screen", bus.screen, m_screen);
        check("game_rst", bus.game_rst, m_grst);
        check("frame_cnt", bus.frame_cnt, m_frames);
        if (bus.game_rst === 1'b1) grst_cnt++;
        if (bus.screen === PLAYER_1) seen_p1 = 1;
        if (bus.screen === PLAYER_2) seen_p2 = 1;
    endtask

    task automatic run_until(input int target, input bit b);
        while (cyc < target) step(0, b, 0, 0);
    endtask

    initial begin
        bit b_lvl;
        // 1: reset then start
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("t1_reset_screen", bus.screen, START);
        check("t1_reset_cnt", bus.frame_cnt, 0);
        run_until(5, 0);
        step(0, 1, 0, 0);
        run_until(15, 0);
        check("t1_start_hold", bus.screen, START);
        step(0, 0, 0, 0);
        check("t1_game", bus.screen, GAME);
        check("t1_grst", bus.game_rst, 1);
        step(0, 0, 0, 0);
        check("t1_grst_off", bus.game_rst, 0);

        // 2: player-2 win and timeout
        run_until(20, 0);
        step(0, 0, 0, 1);
        run_until(36, 0);
        check("t2_p2", bus.screen, PLAYER_2);
        check("t2_cnt0", bus.frame_cnt, 0);
        run_until(56, 0);
        check("t2_cnt1", bus.frame_cnt, 1);
        run_until(76, 0);
        check("t2_cnt2", bus.frame_cnt, 2);
        run_until(96, 0);
        check("t2_timeout", bus.screen, START);
        check("t2_cnt_clr", bus.frame_cnt, 0);

        // 3: simultaneous wins
        run_until(100, 0);
        step(0, 1, 0, 0);
        run_until(116, 0);
        check("t3_game", bus.screen, GAME);
        seen_p2 = 0;
        run_until(120, 0);
        step(0, 0, 1, 1);
        run_until(136, 0);
        check("t3_p1", bus.screen, PLAYER_1);
        run_until(156, 0);
        check("t4_p1_cnt1", bus.frame_cnt, 1);

        // 4: start on a win screen, then press during GAME
        run_until(160, 0);
        step(0, 1, 0, 0);
        run_until(176, 0);
        check("t4_start", bus.screen, START);
        check("t3_no_p2", seen_p2, 0);
        run_until(180, 0);
        step(0, 1, 0, 0);
        run_until(196, 0);
        check("t4_game", bus.screen, GAME);
        run_until(200, 0);
        step(0, 1, 0, 0);
        run_until(216, 0);
        check("t4_press_ignored", bus.screen, GAME);
        run_until(220, 0);
        step(0, 0, 1, 0);
        run_until(296, 0);
        check("t4_timeout", bus.screen, START);

        // 5: request coincident with the tick, then a long press
        run_until(315, 0);
        step(0, 1, 0, 0);
        check("t5_coinc_hold", bus.screen, START);
        run_until(336, 0);
        check("t5_coinc_game", bus.screen, GAME);
        run_until(340, 0);
        step(0, 0, 0, 1);
        run_until(360, 0);
        step(0, 1, 0, 0);
        run_until(376, 0);
        check("t5_back_start", bus.screen, START);
        run_until(380, 0);
        grst_cnt = 0;
        run_until(480, 1);
        run_until(500, 0);
        check("t5_one_entry", grst_cnt, 1);
        check("t5_game", bus.screen, GAME);

        // 6: reset mid-game with a pending win
        run_until(505, 0);
        step(0, 0, 1, 0);
        run_until(510, 0);
        step(1, 0, 0, 0);
        check("t6_rst_screen", bus.screen, START);
        check("t6_rst_cnt", bus.frame_cnt, 0);
        seen_p1 = 0;
        run_until(560, 0);
        check("t6_no_p1", seen_p1, 0);

        // randomized play checked against the model every cycle
        b_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, p1, p2;
            if ($urandom_range(0, 29) == 0) b_lvl = ~b_lvl;
            r  = ($urandom_range(0, 599) == 0);
            p1 = ($urandom_range(0, 49) == 0);
            p2 = ($urandom_range(0, 49) == 0);
            step(r, b_lvl, p1, p2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level game-flow controller that produces the `screen` selection (START, GAME, PLAYER_1, PLAYER_2 from `vga_pkg::state`) consumed by the screen selector. It decides which screen is shown, based on the start button and the win events reported by the game logic. Screen changes take effect only at a frame boundary, so a screen switch never tears the picture. It also issues a one-cycle reset pulse to the game logic on each new game.

## Interface
- `WIN_FRAMES`, default 300. Number of frame boundaries a win screen stays up before the block returns to START automatically. Legal range is 1 or more.
- `clk`  input  1  pixel clock, shared with the VGA timing chain.
- `rst`  input  1  synchronous, active-high reset.
- `vblnk`  input  1  vertical blank from the VGA timing interface. Its rising edge marks a frame boundary.
- `btn_start`  input  1  start button level, already synchronised to `clk`.
- `p1_won`  input  1  player-1 win event from the game logic. It may be a pulse or a level.
- `p2_won`  input  1  player-2 win event. Same format as `p1_won`.
- `screen`  output  `state`  current screen, registered.
- `game_rst`  output  1  one-cycle pulse when GAME is entered, registered.
- `frame_cnt`  output  $clog2(WIN_FRAMES+1)  frames elapsed on the current win screen, registered. It is 0 on every other screen.

## Operation
- **Edge detection.**
  - `vblnk_q` and `btn_q` are registered copies of the inputs.
  - `frame_tick = vblnk & ~vblnk_q`.
  - `start_edge = btn_start & ~btn_q`.
- **Pending requests.** Requests are latched in sticky flags. They are applied and cleared at the next `frame_tick`.
  - `start_req` is set by `start_edge` in the START, PLAYER_1 and PLAYER_2 states. It is ignored in GAME.
  - `win1_req` is set when `p1_won` is high in GAME.
  - `win2_req` is set when `p2_won` is high in GAME.
  - Win inputs are ignored in every other state.
- **Tie-break.** If both win requests are pending at a tick, player 1 wins and both flags clear.
- **States and transitions.** All transitions happen only in a cycle where `frame_tick` = 1.
  - START → GAME when `start_req`. Assert `game_rst` for 1 cycle.
  - GAME → PLAYER_1 when `win1_req`. Otherwise GAME → PLAYER_2 when `win2_req`.
  - PLAYER_1 / PLAYER_2 → START when `start_req` is pending.
  - PLAYER_1 / PLAYER_2 → START when `frame_cnt == WIN_FRAMES-1` at the tick (timeout).
  - While no transition occurs on a win screen, each tick increments `frame_cnt`.
  - Entering any state clears `frame_cnt` to 0.
- **Flag clearing on transition.** Every transition clears all pending flags, including a `start_edge` that arrives in the same cycle. A press must therefore occur after the switch to count.
- **Illegal encoding.** An illegal `screen` encoding goes to START on the next cycle, without waiting for a frame boundary.

## Timing
- **Reset.** On reset: `screen`=START, `game_rst`=0, `frame_cnt`=0, all pending flags 0, `vblnk_q`=0, `btn_q`=0.
- **Reset mid-game.** A reset in any state returns to START on the next edge. Pending requests are discarded.
- **Request latency.** A request in cycle N is applied at the first `frame_tick` in a cycle at or after N+1.
  - `screen` changes at the edge ending the tick cycle and is visible from the next cycle.
  - The worst case is one full frame.
- **`game_rst` timing.** `game_rst` is high in exactly the first cycle in which `screen`==GAME.
- **Long presses.** A button held across several frames produces exactly one `start_edge`.
- **Simultaneous request and tick.** A request arriving in the same cycle as `frame_tick` is not applied at that tick. It stays pending for the next tick, unless the tick causes a transition, in which case it is cleared.
- **Timeout duration.** The timeout leaves a win screen after exactly `WIN_FRAMES` ticks counted from entry. `WIN_FRAMES`=1 leaves at the first tick.
- **Counter range.** `frame_cnt` never exceeds `WIN_FRAMES-1`, so it never wraps.

## Test plan
Bench configuration: `WIN_FRAMES`=3, with a frame every 20 cycles (`vblnk` high for cycles 15–19 of each frame).

1. **Reset then start.** Assert `rst` for 2 cycles, then press `btn_start` for 1 cycle at cycle 5.
   - `screen` stays START until the tick at cycle 15. It reads GAME from cycle 16.
   - `game_rst` = 1 only at cycle 16.
2. **Player-2 win.** In GAME, pulse `p2_won` for 1 cycle.
   - `screen` = PLAYER_2 after the next tick.
   - `frame_cnt` reads 0, 1, 2 over successive frames.
   - `screen` = START after the 3rd tick, with `frame_cnt`=0.
3. **Simultaneous wins.** Pulse `p1_won` and `p2_won` in the same cycle in GAME.
   - `screen` = PLAYER_1 after the next tick.
   - No later transition to PLAYER_2.
4. **Start on a win screen and press during GAME.**
   - Press start on PLAYER_1 with `frame_cnt`=1 → START at the next tick, with no `game_rst`.
   - A press during GAME has no effect.
5. **Request coincident with the tick.**
   - A `start_edge` in the same cycle as `frame_tick` while in START → GAME one frame later.
   - A button held for 100 cycles in START yields exactly one GAME entry.
6. **Reset mid-game.** Assert `rst` while in GAME with `win1_req` pending.
   - `screen` = START and `frame_cnt` = 0 the next cycle.
   - No PLAYER_1 screen appears afterwards.
